// File: rtl/rgb_process_pipe.sv
// Two-stage RGB pixel pipeline: per-frame gain/attenuation, corner markers and an optional cursor box.
// Define RGB_PROCESS_CURSOR_EN to build the movable cursor; without it curs_row/curs_col are fixed at frame centre.
module rgb_process_pipe #(
  parameter int DATA_W    = 8,
  parameter int COORD_W   = 13,
  parameter int FRAME_W   = 640,
  parameter int FRAME_H   = 480,
  parameter int MARK      = 5,
  parameter int CURS_SIZE = 8,
  parameter int CURS_STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               i_valid,
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  input  logic [DATA_W-1:0]  i_R,
  input  logic [DATA_W-1:0]  i_G,
  input  logic [DATA_W-1:0]  i_B,
  input  logic               bright_mode,
  input  logic [1:0]         level,
  input  logic [2:0]         ch_en,
  input  logic               curs_up,
  input  logic               curs_down,
  input  logic               curs_left,
  input  logic               curs_right,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_R,
  output logic [DATA_W-1:0]  o_G,
  output logic [DATA_W-1:0]  o_B,
  output logic [COORD_W-1:0] curs_row,
  output logic [COORD_W-1:0] curs_col
);

  localparam logic [DATA_W-1:0]  PIX_MAX     = '1;
  localparam logic [COORD_W-1:0] MARK_C      = COORD_W'(MARK);
  localparam logic [COORD_W-1:0] W_C         = COORD_W'(FRAME_W);
  localparam logic [COORD_W-1:0] H_C         = COORD_W'(FRAME_H);
  localparam logic [COORD_W-1:0] RIGHT_MARK  = COORD_W'(FRAME_W - MARK);
  localparam logic [COORD_W-1:0] BOTTOM_MARK = COORD_W'(FRAME_H - MARK);
  localparam logic [COORD_W-1:0] COL_HOME    = COORD_W'(FRAME_W / 2);
  localparam logic [COORD_W-1:0] ROW_HOME    = COORD_W'(FRAME_H / 2);

  logic              ctl_bright;
  logic [1:0]        ctl_level;
  logic [2:0]        ctl_ch_en;
  logic              eff_bright;
  logic [1:0]        eff_level;
  logic [2:0]        eff_ch_en;
  logic              in_curs;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_R, s1_G, s1_B;
  logic [DATA_W-1:0] nxt_R, nxt_G, nxt_B;

  function automatic logic [DATA_W-1:0] apply_gain(input logic [DATA_W-1:0] x,
                                                   input logic [1:0] lvl);
    logic [DATA_W+2:0] xw;
    logic [DATA_W+2:0] acc;
    xw = {3'b000, x};
    case (lvl)
      2'd0:    acc = xw >> 1;
      2'd1:    acc = xw;
      2'd2:    acc = ((xw << 2) + xw) >> 2;
      default: acc = ((xw << 2) + (xw << 1)) >> 2;
    endcase
    if (acc > {3'b000, PIX_MAX}) apply_gain = PIX_MAX;
    else                         apply_gain = acc[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] apply_atten(input logic [DATA_W-1:0] x,
                                                    input logic [1:0] lvl,
                                                    input logic en);
    if (!en) apply_atten = x;
    else begin
      case (lvl)
        2'd0:    apply_atten = '0;
        2'd1:    apply_atten = x >> 2;
        2'd2:    apply_atten = x >> 1;
        default: apply_atten = x;
      endcase
    end
  endfunction

  function automatic logic [DATA_W-1:0] process_chan(input logic [DATA_W-1:0] x,
                                                     input logic bright,
                                                     input logic [1:0] lvl,
                                                     input logic en);
    if (bright) process_chan = apply_gain(x, lvl);
    else        process_chan = apply_atten(x, lvl, en);
  endfunction

  // A frame_start pixel already sees the controls being latched on that cycle.
  always_comb begin
    eff_bright = ctl_bright;
    eff_level  = ctl_level;
    eff_ch_en  = ctl_ch_en;
    if (frame_start) begin
      eff_bright = bright_mode;
      eff_level  = level;
      eff_ch_en  = ch_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_bright <= 1'b0;
      ctl_level  <= 2'd3;
      ctl_ch_en  <= 3'b000;
    end else if (frame_start) begin
      ctl_bright <= bright_mode;
      ctl_level  <= level;
      ctl_ch_en  <= ch_en;
    end
  end

`ifdef RGB_PROCESS_CURSOR_EN
  localparam logic [COORD_W-1:0] HALF_C  = COORD_W'(CURS_SIZE / 2);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(CURS_STEP);
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(FRAME_W - 1 - CURS_SIZE / 2);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(FRAME_H - 1 - CURS_SIZE / 2);

  logic [COORD_W-1:0] curs_row_q, curs_col_q;
  logic [COORD_W-1:0] curs_row_n, curs_col_n;

  // Each axis moves independently; the clamp tests avoid any under/overflow of the centre.
  always_comb begin
    curs_row_n = curs_row_q;
    curs_col_n = curs_col_q;
    if (frame_start) begin
      if (curs_right && !curs_left)
        curs_col_n = (curs_col_q >= COL_MAX - STEP_C) ? COL_MAX : curs_col_q + STEP_C;
      else if (curs_left && !curs_right)
        curs_col_n = (curs_col_q <= HALF_C + STEP_C) ? HALF_C : curs_col_q - STEP_C;
      if (curs_down && !curs_up)
        curs_row_n = (curs_row_q >= ROW_MAX - STEP_C) ? ROW_MAX : curs_row_q + STEP_C;
      else if (curs_up && !curs_down)
        curs_row_n = (curs_row_q <= HALF_C + STEP_C) ? HALF_C : curs_row_q - STEP_C;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curs_row_q <= ROW_HOME;
      curs_col_q <= COL_HOME;
    end else begin
      curs_row_q <= curs_row_n;
      curs_col_q <= curs_col_n;
    end
  end

  assign curs_row = curs_row_q;
  assign curs_col = curs_col_q;
  assign in_curs  = (i_row >= curs_row_q - HALF_C) && (i_row <= curs_row_q + HALF_C) &&
                    (i_col >= curs_col_q - HALF_C) && (i_col <= curs_col_q + HALF_C);
`else
  logic unused_curs;
  assign unused_curs = ^{curs_up, curs_down, curs_left, curs_right};
  assign curs_row    = ROW_HOME;
  assign curs_col    = COL_HOME;
  assign in_curs     = 1'b0;
`endif

  // Stage-1 region selection, highest priority first.
  always_comb begin
    nxt_R = '0;
    nxt_G = '0;
    nxt_B = '0;
    if (i_row < MARK_C && i_col < MARK_C) begin
      nxt_R = PIX_MAX;
    end else if (i_row < MARK_C && i_col >= RIGHT_MARK && i_col < W_C) begin
      nxt_G = PIX_MAX;
    end else if (i_row >= BOTTOM_MARK && i_row < H_C && i_col < MARK_C) begin
      nxt_B = PIX_MAX;
    end else if (in_curs) begin
      nxt_G = PIX_MAX;
    end else if (i_row < H_C && i_col < W_C) begin
      nxt_R = process_chan(i_R, eff_bright, eff_level, eff_ch_en[2]);
      nxt_G = process_chan(i_G, eff_bright, eff_level, eff_ch_en[1]);
      nxt_B = process_chan(i_B, eff_bright, eff_level, eff_ch_en[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_R     <= '0;
      s1_G     <= '0;
      s1_B     <= '0;
      o_valid  <= 1'b0;
      o_R      <= '0;
      o_G      <= '0;
      o_B      <= '0;
    end else begin
      s1_valid <= i_valid;
      s1_R     <= nxt_R;
      s1_G     <= nxt_G;
      s1_B     <= nxt_B;
      o_valid  <= s1_valid;
      o_R      <= s1_R;
      o_G      <= s1_G;
      o_B      <= s1_B;
    end
  end

endmodule

// File: tb/tb_rgb_process_pipe.sv
// Self-checking bench for rgb_process_pipe: a behavioural model compared every cycle plus literal spot checks.
// Cursor-specific sequences follow RGB_PROCESS_CURSOR_EN the same way the design does.
module tb_rgb_process_pipe;

  localparam int DATA_W = 8, COORD_W = 13, FRAME_W = 640, FRAME_H = 480;
  localparam int MARK = 5, CURS_SIZE = 8, CURS_STEP = 4;
  localparam int PMAX = (1 << DATA_W) - 1;
`ifdef RGB_PROCESS_CURSOR_EN
  localparam bit CURSOR_EN = 1'b1;
`else
  localparam bit CURSOR_EN = 1'b0;
`endif

  logic clk, reset, frame_start, i_valid, bright_mode;
  logic [COORD_W-1:0] i_row, i_col;
  logic [DATA_W-1:0] i_R, i_G, i_B;
  logic [1:0] level;
  logic [2:0] ch_en;
  logic curs_up, curs_down, curs_left, curs_right;
  logic o_valid;
  logic [DATA_W-1:0] o_R, o_G, o_B;
  logic [COORD_W-1:0] curs_row, curs_col;

  int checks = 0;
  int failures = 0;

  rgb_process_pipe #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H),
    .MARK(MARK), .CURS_SIZE(CURS_SIZE), .CURS_STEP(CURS_STEP)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .i_valid(i_valid),
    .i_row(i_row), .i_col(i_col), .i_R(i_R), .i_G(i_G), .i_B(i_B),
    .bright_mode(bright_mode), .level(level), .ch_en(ch_en),
    .curs_up(curs_up), .curs_down(curs_down), .curs_left(curs_left), .curs_right(curs_right),
    .o_valid(o_valid), .o_R(o_R), .o_G(o_G), .o_B(o_B),
    .curs_row(curs_row), .curs_col(curs_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int r, g, b;
  } pix_t;

  pix_t m_stage, m_out;
  bit m_bright = 0;
  int m_level = 3;
  int m_ch_en = 0;
  int m_crow = FRAME_H / 2;
  int m_ccol = FRAME_W / 2;
  bit model_ready = 0;

  function automatic int chanModel(int x, bit bright, int lvl, bit en);
    int y;
    if (bright) begin
      y = (lvl == 0) ? x / 2 : (lvl == 1) ? x : (lvl == 2) ? (5 * x) / 4 : (6 * x) / 4;
      if (y > PMAX) y = PMAX;
    end else if (!en) y = x;
    else y = (lvl == 0) ? 0 : (lvl == 1) ? x / 4 : (lvl == 2) ? x / 2 : x;
    return y;
  endfunction

  function automatic int absInt(int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int clampInt(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic pix_t pixelModel(int row, int col, int r, int g, int b, bit bright,
                                      int lvl, int en, int crow, int ccol);
    pix_t p;
    p.v = 1; p.r = 0; p.g = 0; p.b = 0;
    if (row < MARK && col < MARK) p.r = PMAX;
    else if (row < MARK && col >= FRAME_W - MARK && col < FRAME_W) p.g = PMAX;
    else if (row >= FRAME_H - MARK && row < FRAME_H && col < MARK) p.b = PMAX;
    else if (CURSOR_EN && absInt(row - crow) <= CURS_SIZE / 2 && absInt(col - ccol) <= CURS_SIZE / 2)
      p.g = PMAX;
    else if (row < FRAME_H && col < FRAME_W) begin
      p.r = chanModel(r, bright, lvl, en[2]);
      p.g = chanModel(g, bright, lvl, en[1]);
      p.b = chanModel(b, bright, lvl, en[0]);
    end
    return p;
  endfunction

  // Reference model: inputs are stable at the rising edge, outputs are two pixels behind.
  always @(posedge clk) begin
    pix_t nxt;
    if (reset) begin
      m_stage = '{0, 0, 0, 0};
      m_out = '{0, 0, 0, 0};
      m_bright = 0; m_level = 3; m_ch_en = 0;
      m_crow = FRAME_H / 2; m_ccol = FRAME_W / 2;
    end else begin
      bit eb; int el, ee;
      eb = frame_start ? bright_mode : m_bright;
      el = frame_start ? int'(level) : m_level;
      ee = frame_start ? int'(ch_en) : m_ch_en;
      nxt = '{0, 0, 0, 0};
      if (i_valid)
        nxt = pixelModel(int'(i_row), int'(i_col), int'(i_R), int'(i_G), int'(i_B), eb, el, ee, m_crow, m_ccol);
      m_out = m_stage;
      m_stage = nxt;
      if (frame_start) begin
        m_bright = eb; m_level = el; m_ch_en = ee;
        if (CURSOR_EN) begin
          m_ccol = clampInt(m_ccol + CURS_STEP * (int'(curs_right) - int'(curs_left)),
                            CURS_SIZE / 2, FRAME_W - 1 - CURS_SIZE / 2);
          m_crow = clampInt(m_crow + CURS_STEP * (int'(curs_down) - int'(curs_up)),
                            CURS_SIZE / 2, FRAME_H - 1 - CURS_SIZE / 2);
        end
      end
    end
    model_ready = 1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checks++;
      if (o_valid !== m_out.v) begin
        failures++;
        $display("[TB] FAIL cmp_valid t=%0t got=%b want=%b", $time, o_valid, m_out.v);
      end
      checks++;
      if (int'(curs_row) != m_crow || int'(curs_col) != m_ccol || $isunknown({curs_row, curs_col})) begin
        failures++;
        $display("[TB] FAIL cmp_curs t=%0t got=(%0d,%0d) want=(%0d,%0d)", $time, curs_row, curs_col, m_crow, m_ccol);
      end
      if (m_out.v) begin
        checks++;
        if (int'(o_R) != m_out.r || int'(o_G) != m_out.g || int'(o_B) != m_out.b || $isunknown({o_R, o_G, o_B})) begin
          failures++;
          $display("[TB] FAIL cmp_rgb t=%0t got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", $time,
                   o_R, o_G, o_B, m_out.r, m_out.g, m_out.b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic fs, input int row, input int col,
                               input int r, input int g, input int b);
    i_valid = v; frame_start = fs;
    i_row = COORD_W'(row); i_col = COORD_W'(col);
    i_R = DATA_W'(r); i_G = DATA_W'(g); i_B = DATA_W'(b);
    tick();
    i_valid = 0; frame_start = 0;
    curs_up = 0; curs_down = 0; curs_left = 0; curs_right = 0;
  endtask

  task automatic checkValue(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input int er, input int eg, input int eb);
    checks++;
    if (o_valid !== 1'b1 || int'(o_R) != er || int'(o_G) != eg || int'(o_B) != eb) begin
      failures++;
      $display("[TB] FAIL %s got v=%b (%0d,%0d,%0d) want v=1 (%0d,%0d,%0d)", name,
               o_valid, o_R, o_G, o_B, er, eg, eb);
    end
  endtask

  // One pixel, then read the output two edges after it was sampled.
  task automatic pixelCheck(input string name, input logic fs, input int row, input int col,
                            input int r, input int g, input int b,
                            input int er, input int eg, input int eb);
    applyStimulus(1, fs, row, col, r, g, b);
    tick();
    checkOutput(name, er, eg, eb);
  endtask

  initial begin
    reset = 1; frame_start = 0; i_valid = 0; i_row = '0; i_col = '0;
    i_R = '0; i_G = '0; i_B = '0; bright_mode = 0; level = 2'd0; ch_en = 3'b000;
    curs_up = 0; curs_down = 0; curs_left = 0; curs_right = 0;
    tick(); tick(); tick();
    checkValue("rst_valid", int'(o_valid), 0);
    checkValue("rst_rgb", int'(o_R) + int'(o_G) + int'(o_B), 0);
    checkValue("rst_curs_row", int'(curs_row), 240);
    checkValue("rst_curs_col", int'(curs_col), 320);
    reset = 0;
    tick();

    pixelCheck("passthru", 0, 100, 100, 80, 40, 200, 80, 40, 200);

    bright_mode = 1; level = 2'd3;
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    pixelCheck("gain_l3", 0, 100, 100, 200, 100, 4, 255, 150, 6);
    level = 2'd2;
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    pixelCheck("gain_l2", 0, 100, 100, 200, 100, 4, 250, 125, 5);
    level = 2'd0;
    pixelCheck("same_cycle_fs", 1, 100, 100, 200, 100, 4, 100, 50, 2);
    bright_mode = 0; level = 2'd0; ch_en = 3'b111;
    pixelCheck("midframe_ignored", 0, 100, 100, 200, 100, 4, 100, 50, 2);

    bright_mode = 0; ch_en = 3'b101; level = 2'd1;
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    pixelCheck("atten_l1", 0, 100, 100, 100, 100, 100, 25, 100, 25);
    pixelCheck("mark_red", 0, 2, 2, 100, 100, 100, 255, 0, 0);
    pixelCheck("mark_green", 0, 2, 637, 100, 100, 100, 0, 255, 0);
    pixelCheck("mark_blue", 0, 477, 1, 100, 100, 100, 0, 0, 255);
    pixelCheck("corner_br", 0, 479, 639, 100, 100, 100, 25, 100, 25);
    pixelCheck("outside", 0, 480, 10, 100, 100, 100, 0, 0, 0);

    // Sweep both modes and every level back-to-back; the per-cycle compare covers these.
    ch_en = 3'b110;
    for (int m = 0; m < 2; m++) begin
      for (int l = 0; l < 4; l++) begin
        bright_mode = m[0]; level = l[1:0];
        applyStimulus(1, 1, 50, 60, 0, 128, 255);
        applyStimulus(1, 0, 51, 60, 9, 33, 77);
      end
    end
    tick(); tick();
    bright_mode = 1; level = 2'd2;
    pixelCheck("gain_sat", 1, 50, 60, 0, 128, 255, 0, 160, 255);

`ifdef RGB_PROCESS_CURSOR_EN
    for (int k = 0; k < 200; k++) begin
      curs_right = 1;
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
    end
    checkValue("curs_col_clamp", int'(curs_col), 635);
    curs_left = 1; curs_right = 1; curs_up = 1;
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkValue("curs_col_oppose", int'(curs_col), 635);
    checkValue("curs_row_up", int'(curs_row), 236);
    pixelCheck("curs_overlay", 0, 236, 635, 10, 20, 30, 0, 255, 0);
`else
    bright_mode = 0; ch_en = 3'b101; level = 2'd1;
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    pixelCheck("no_curs_overlay", 0, 240, 320, 100, 100, 100, 25, 100, 25);
    for (int k = 0; k < 3; k++) begin
      curs_right = 1;
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
    end
    checkValue("no_curs_col", int'(curs_col), 320);
`endif

    curs_right = 1; curs_down = 1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkValue("move_no_fs_col", int'(curs_col), CURSOR_EN ? 635 : 320);

    applyStimulus(1, 0, 100, 100, 1, 2, 3);
    reset = 1;
    tick();
    checkValue("rst_flush_v1", int'(o_valid), 0);
    tick();
    checkValue("rst_flush_v2", int'(o_valid), 0);
    checkValue("rst_curs_row2", int'(curs_row), 240);
    checkValue("rst_curs_col2", int'(curs_col), 320);
    reset = 0;
    tick();
    checkValue("post_rst_idle", int'(o_valid), 0);
    pixelCheck("post_rst_passthru", 0, 10, 10, 7, 8, 9, 7, 8, 9);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_process_pipe.md
RGB_PROCESS_PIPE -- requirements
Module: rgb_process_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning per-channel pixel width.
REQ-002 SHALL have parameter COORD_W, default 13, meaning row/col width.
REQ-003 SHALL have parameters FRAME_W = 640 and FRAME_H = 480, meaning active area size in pixels.
REQ-004 SHALL have parameter MARK, default 5, meaning corner marker square size; CURS_SIZE, default 8, meaning cursor box size; CURS_STEP, default 4, meaning cursor move in pixels per frame.
REQ-005 SHALL have a single clock (clk) and a synchronous, active-high reset (reset).
REQ-006 Ports, clock and reset first:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per frame.
- i_valid  in  1  pixel qualifier.
- i_row, i_col  in  COORD_W  pixel coordinates.
- i_R, i_G, i_B  in  DATA_W  raw pixel.
- bright_mode  in  1  1 selects gain, 0 selects attenuation.
- level  in  2  gain or attenuation step.
- ch_en  in  3  {R,G,B} attenuation enables.
- curs_up, curs_down, curs_left, curs_right  in  1  each  cursor move requests.
- o_valid  out  1  output qualifier.
- o_R, o_G, o_B  out  DATA_W  processed pixel.
- curs_row, curs_col  out  COORD_W  cursor centre.

Function
REQ-007 The block SHALL latch bright_mode, level and ch_en only on a cycle with frame_start=1; mid-frame changes SHALL take effect from the next frame_start.
REQ-008 The pipeline SHALL be 2 stages: o_valid and o_R/G/B appear exactly 2 cycles after i_valid; o_valid = i_valid delayed 2; no stall, no backpressure.
REQ-009 Stage-1 region priority, highest first:
- rows [0,MARK), cols [0,MARK): red (R=max, G=0, B=0).
- rows [0,MARK), cols [FRAME_W-MARK,FRAME_W): green.
- rows [FRAME_H-MARK,FRAME_H), cols [0,MARK): blue.
- cursor box: green.
- in active area: processed pixel.
- outside active area: 0.
REQ-010 Gain, bright_mode=1, all channels: level 0 -> x>>1; level 1 -> x; level 2 -> floor(5x/4); level 3 -> floor(6x/4). Results SHALL saturate at 2^DATA_W-1, with intermediates at DATA_W+3 bits.
REQ-011 Attenuation, bright_mode=0, per channel: ch_en bit 0 -> x. Otherwise level 0 -> 0; level 1 -> x>>2; level 2 -> x>>1; level 3 -> x.
REQ-012 Cursor box SHALL be the inclusive range rows curs_row +/- CURS_SIZE/2, cols curs_col +/- CURS_SIZE/2.
REQ-013 On frame_start, cursor movement SHALL be:
- curs_right alone: curs_col += CURS_STEP; curs_left alone: curs_col -= CURS_STEP.
- curs_down alone: curs_row += CURS_STEP; curs_up alone: curs_row -= CURS_STEP.
- Horizontal and vertical axes SHALL be independent, so diagonal moves are allowed; opposing requests on one axis SHALL leave that axis unchanged.
REQ-014 Cursor centre SHALL clamp to col [CURS_SIZE/2, FRAME_W-1-CURS_SIZE/2] and row [CURS_SIZE/2, FRAME_H-1-CURS_SIZE/2], with no wrap-around.
REQ-015 Move requests without frame_start SHALL be ignored.
REQ-016 A frame_start coinciding with i_valid SHALL use the newly latched controls for that same pixel.

Reset
REQ-017 While reset=1 at a clk edge, the block SHALL clear o_valid, o_R/G/B and all pipeline valids to 0.
REQ-018 While reset=1 at a clk edge, the block SHALL set latched bright_mode=0, level=3, ch_en=0 (passthrough).
REQ-019 While reset=1 at a clk edge, the block SHALL set curs_row=FRAME_H/2 and curs_col=FRAME_W/2.
REQ-020 Reset mid-frame SHALL discard in-flight pixels; o_valid SHALL stay 0 until 2 cycles after the first post-reset i_valid.

Configuration
REQ-021 Macro RGB_PROCESS_CURSOR_EN defined: cursor registers, move logic and overlay SHALL be present.
REQ-022 Macro RGB_PROCESS_CURSOR_EN undefined: there SHALL be no cursor registers or overlay; curs_row/curs_col SHALL be tied to FRAME_H/2 and FRAME_W/2; move inputs SHALL be ignored; the cursor region SHALL fall through to the processed pixel.

Verification
REQ-023 Reset, then i_valid=1, (row,col)=(100,100), RGB=(80,40,200) -> 2 cycles later o_valid=1, output (80,40,200).
REQ-024 frame_start with bright_mode=1, level=3, then pixel (100,100), RGB=(200,100,4) -> output (255,150,6); level=2 on the next frame -> (250,125,5).
REQ-025 bright_mode=0, ch_en=3'b101, level=1, RGB=(100,100,100) -> output (25,100,25); pixel (2,2) -> (255,0,0); pixel (477,1) -> (0,0,255); pixel (479,639) -> active-area processed value, not a marker.
REQ-026 curs_right held across 200 frame_starts -> curs_col stops at 635; curs_left+curs_right with curs_up -> col unchanged, row -4; pixel (curs_row, curs_col) -> (0,255,0).
REQ-027 reset asserted 1 cycle after i_valid -> o_valid never rises for that pixel; curs returns to (240,320).
REQ-028 Build without RGB_PROCESS_CURSOR_EN -> pixel (240,320) is processed, not green; curs_right pulses leave curs_col=320.
